dmem_c2c_slave: RTL and testbench

DMEM_C2C_SLAVE -- requirements
Module: dmem_c2c_slave

---
 rtl/dmem_c2c_slave_if.sv | 25 ++
 rtl/dmem_c2c_slave.sv | 117 +++++++++++
 tb/tb_dmem_c2c_slave.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_c2c_slave_if.sv
// LSU-to-data-memory bus: independent read and write request channels, each closed by a one-cycle ack.
interface dmem_c2c_slave_if #(
  parameter int XLEN = 32
);
  logic              dr_re;
  logic [XLEN/8-1:0] dr_sel;
  logic [XLEN-1:0]   dr_addr;
  logic              dr_ack;
  logic [XLEN-1:0]   dr_data;
  logic              dw_we;
  logic [XLEN/8-1:0] dw_sel;
  logic [XLEN-1:0]   dw_addr;
  logic [XLEN-1:0]   dw_data;
  logic              dw_ack;

  modport master (
    output dr_re, dr_sel, dr_addr, dw_we, dw_sel, dw_addr, dw_data,
    input  dr_ack, dr_data, dw_ack
  );

  modport slave (
    input  dr_re, dr_sel, dr_addr, dw_we, dw_sel, dw_addr, dw_data,
    output dr_ack, dr_data, dw_ack
  );
endinterface

// File: rtl/dmem_c2c_slave.sv
// Single-port data memory slave: one outstanding access, ack LATENCY+1 cycles after the request is sampled.
// No queuing: the master holds its request until ack; requests are only sampled while idle, write first.
module dmem_c2c_slave #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_c2c_slave_if.slave  bus,
  output logic             busy
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int LANES = XLEN / 8;
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic             lat_we;
  logic             lat_oor;
  logic [IDX_W-1:0] lat_idx;
  logic [LANES-1:0] lat_sel;
  logic [XLEN-1:0]  lat_data;
  logic [XLEN-1:0]  mem [DEPTH_WORDS];

  // Write wins a same-cycle collision; the read stays raised and is taken on a later idle cycle.
  logic             req_vld;
  logic             req_we;
  logic [XLEN-1:0]  req_addr;
  logic [IDX_W-1:0] req_idx;
  logic             req_oor;
  logic [LANES-1:0] req_sel;
  logic [XLEN-1:0]  rd_req;
  logic [XLEN-1:0]  rd_lat;
  logic             unused_ok;

  assign req_vld   = bus.dw_we | bus.dr_re;
  assign req_we    = bus.dw_we;
  assign req_addr  = req_we ? bus.dw_addr : bus.dr_addr;
  assign req_idx   = req_addr[IDX_W+1:2];
  assign req_oor   = |req_addr[XLEN-1:IDX_W+2];
  assign req_sel   = req_we ? bus.dw_sel : bus.dr_sel;
  assign unused_ok = ^req_addr[1:0];

  assign rd_req = req_oor ? '0 : mem[req_idx];
  assign rd_lat = lat_oor ? '0 : mem[lat_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      busy        <= 1'b0;
      bus.dr_ack  <= 1'b0;
      bus.dw_ack  <= 1'b0;
      bus.dr_data <= '0;
      lat_we      <= 1'b0;
      lat_oor     <= 1'b0;
      lat_idx     <= '0;
      lat_sel     <= '0;
      lat_data    <= '0;
    end else begin
      bus.dr_ack  <= 1'b0;
      bus.dw_ack  <= 1'b0;
      bus.dr_data <= '0;
      case (state)
        IDLE: begin
          if (req_vld) begin
            lat_we   <= req_we;
            lat_oor  <= req_oor;
            lat_idx  <= req_idx;
            lat_sel  <= req_sel;
            lat_data <= bus.dw_data;
            busy     <= 1'b1;
            if (LATENCY == 0) begin
              state       <= RESP;
              bus.dw_ack  <= req_we;
              bus.dr_ack  <= !req_we;
              bus.dr_data <= req_we ? '0 : rd_req;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state       <= RESP;
            bus.dw_ack  <= lat_we;
            bus.dr_ack  <= !lat_we;
            bus.dr_data <= lat_we ? '0 : rd_lat;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; a write lands on the edge that closes its ack cycle.
  always_ff @(posedge clk) begin
    if (rst_n && state == RESP && lat_we && !lat_oor) begin
      for (int i = 0; i < LANES; i++) begin
        if (lat_sel[i]) mem[lat_idx][8*i +: 8] <= lat_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_c2c_slave.sv
// Bench for dmem_c2c_slave: a LATENCY=1 and a LATENCY=0 instance share one stimulus source, selected by sel_dut.
module tb_dmem_c2c_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  int          sel_dut;
  logic        s_dr_re, s_dw_we;
  logic [3:0]  s_dr_sel, s_dw_sel;
  logic [31:0] s_dr_addr, s_dw_addr, s_dw_data;
  logic        busy1, busy0;
  logic        on1, on0;

  dmem_c2c_slave_if #(.XLEN(32)) b1 ();
  dmem_c2c_slave_if #(.XLEN(32)) b0 ();

  dmem_c2c_slave #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave), .busy(busy1));
  dmem_c2c_slave #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave), .busy(busy0));

  assign on1 = (sel_dut == 1);
  assign on0 = (sel_dut == 0);
  assign b1.dr_re   = on1 & s_dr_re;
  assign b1.dr_sel  = on1 ? s_dr_sel  : 4'h0;
  assign b1.dr_addr = on1 ? s_dr_addr : 32'h0;
  assign b1.dw_we   = on1 & s_dw_we;
  assign b1.dw_sel  = on1 ? s_dw_sel  : 4'h0;
  assign b1.dw_addr = on1 ? s_dw_addr : 32'h0;
  assign b1.dw_data = on1 ? s_dw_data : 32'h0;
  assign b0.dr_re   = on0 & s_dr_re;
  assign b0.dr_sel  = on0 ? s_dr_sel  : 4'h0;
  assign b0.dr_addr = on0 ? s_dr_addr : 32'h0;
  assign b0.dw_we   = on0 & s_dw_we;
  assign b0.dw_sel  = on0 ? s_dw_sel  : 4'h0;
  assign b0.dw_addr = on0 ? s_dw_addr : 32'h0;
  assign b0.dw_data = on0 ? s_dw_data : 32'h0;

  logic        m_dr_ack, m_dw_ack, m_busy;
  logic [31:0] m_dr_data;
  assign m_dr_ack  = on1 ? b1.dr_ack  : b0.dr_ack;
  assign m_dw_ack  = on1 ? b1.dw_ack  : b0.dw_ack;
  assign m_dr_data = on1 ? b1.dr_data : b0.dr_data;
  assign m_busy    = on1 ? busy1      : busy0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no ack within cycle budget (t=%0t)", name, $time);
  endtask

  // Transaction-level model: accepted at edge e -> ack in cycle e+1+LAT, storage updated at edge e+1+LAT.
  logic [31:0] mmem [int];
  bit          armed = 0;
  bit          in_txn = 0;
  int          edge_n = 0;
  int          t_ack;
  bit          t_we, t_oor;
  int          t_key;
  logic [3:0]  t_sel;
  logic [31:0] t_data, t_rdata, m_addr, m_w;

  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      in_txn = 0;
      armed  = 1;
    end else if (in_txn) begin
      if (edge_n == t_ack) begin
        if (t_we && !t_oor) begin
          m_w = mmem.exists(t_key) ? mmem[t_key] : 32'hx;
          for (int i = 0; i < 4; i++) if (t_sel[i]) m_w[8*i +: 8] = t_data[8*i +: 8];
          mmem[t_key] = m_w;
        end
        in_txn = 0;
      end
    end else if (s_dw_we || s_dr_re) begin
      in_txn  = 1;
      t_ack   = edge_n + 1 + ((sel_dut == 1) ? 1 : 0);
      t_we    = s_dw_we;
      m_addr  = s_dw_we ? s_dw_addr : s_dr_addr;
      t_oor   = |m_addr[31:12];
      t_key   = sel_dut * 4096 + int'(m_addr[11:2]);
      t_sel   = s_dw_sel;
      t_data  = s_dw_data;
      t_rdata = t_oor ? 32'h0 : (mmem.exists(t_key) ? mmem[t_key] : 32'hx);
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      automatic bit ack_now = in_txn && (edge_n + 1 == t_ack);
      chk("dw_ack", {31'b0, m_dw_ack}, {31'b0, ack_now && t_we});
      chk("dr_ack", {31'b0, m_dr_ack}, {31'b0, ack_now && !t_we});
      chk("dr_data", m_dr_data, (ack_now && !t_we) ? t_rdata : 32'h0);
      chk("busy", {31'b0, m_busy}, {31'b0, in_txn});
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl, output int ncyc);
    @(posedge clk); #2;
    s_dw_we = 1'b1; s_dw_addr = a; s_dw_data = d; s_dw_sel = sl;
    ncyc = 0;
    forever begin
      @(negedge clk); ncyc++;
      if (m_dw_ack === 1'b1) break;
      if (ncyc > 40) begin timeout("write_ack"); break; end
    end
    @(posedge clk); #2;
    s_dw_we = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int ncyc);
    @(posedge clk); #2;
    s_dr_re = 1'b1; s_dr_addr = a; s_dr_sel = 4'h3;
    ncyc = 0;
    d = 32'h0;
    forever begin
      @(negedge clk); ncyc++;
      if (m_dr_ack === 1'b1) begin d = m_dr_data; break; end
      if (ncyc > 40) begin timeout("read_ack"); break; end
    end
    @(posedge clk); #2;
    s_dr_re = 1'b0;
  endtask

  initial #300000 begin
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    automatic int nc;
    automatic logic [31:0] rd;
    automatic bit dr_first;
    rst_n = 1'b0; sel_dut = 1;
    s_dr_re = 0; s_dw_we = 0; s_dr_sel = 0; s_dw_sel = 0;
    s_dr_addr = 0; s_dw_addr = 0; s_dw_data = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_dr_ack", {31'b0, m_dr_ack}, 32'd0);
    chk("rst_dw_ack", {31'b0, m_dw_ack}, 32'd0);
    chk("rst_dr_data", m_dr_data, 32'd0);
    chk("rst_busy", {31'b0, m_busy}, 32'd0);

    // Basic write then read, LATENCY=1: ack two cycles after the sampling edge.
    do_write(32'h10, 32'hDEADBEEF, 4'hF, nc);
    chk("wr_lat1_cycles", nc, 32'd3);
    do_read(32'h10, rd, nc);
    chk("rd_lat1_cycles", nc, 32'd3);
    chk("rd_deadbeef", rd, 32'hDEADBEEF);

    // Byte-lane merge, sel=0 write, and ignored low address bits.
    do_write(32'h20, 32'h11223344, 4'hF, nc);
    do_write(32'h20, 32'h0000AA00, 4'h2, nc);
    do_read(32'h20, rd, nc);
    chk("lane_merge", rd, 32'h1122AA44);
    do_write(32'h20, 32'hFFFFFFFF, 4'h0, nc);
    do_read(32'h23, rd, nc);
    chk("sel0_and_addr_lo", rd, 32'h1122AA44);

    // Simultaneous write and read to the same word, both held until their ack.
    @(posedge clk); #2;
    s_dw_we = 1; s_dw_addr = 32'h30; s_dw_data = 32'h5; s_dw_sel = 4'hF;
    s_dr_re = 1; s_dr_addr = 32'h30; s_dr_sel = 4'hF;
    dr_first = 0; nc = 0;
    forever begin
      @(negedge clk); nc++;
      if (m_dr_ack === 1'b1) dr_first = 1;
      if (m_dw_ack === 1'b1) break;
      if (nc > 40) begin timeout("sim_wr_ack"); break; end
    end
    chk("sim_write_first", {31'b0, dr_first}, 32'd0);
    @(posedge clk); #2 s_dw_we = 0;
    nc = 0; rd = 32'h0;
    forever begin
      @(negedge clk); nc++;
      if (m_dr_ack === 1'b1) begin rd = m_dr_data; break; end
      if (nc > 40) begin timeout("sim_rd_ack"); break; end
    end
    chk("sim_rd_data", rd, 32'h5);
    @(posedge clk); #2 s_dr_re = 0;

    // Out-of-range write dropped, read returns zero, word 0 untouched.
    do_write(32'h0, 32'h12345678, 4'hF, nc);
    do_write(32'h1000, 32'hFF, 4'hF, nc);
    chk("oor_wr_acked", nc, 32'd3);
    do_read(32'h1000, rd, nc);
    chk("oor_rd_zero", rd, 32'h0);
    do_read(32'h0, rd, nc);
    chk("oor_word0_kept", rd, 32'h12345678);

    // Reset during the wait phase of a write abandons it.
    do_write(32'h40, 32'h1, 4'hF, nc);
    @(posedge clk); #2;
    s_dw_we = 1; s_dw_addr = 32'h40; s_dw_data = 32'h99; s_dw_sel = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("wait_busy", {31'b0, m_busy}, 32'd1);
    rst_n = 1'b0; s_dw_we = 0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", {31'b0, m_busy}, 32'd0);
    chk("rst_mid_no_ack", {31'b0, m_dw_ack}, 32'd0);
    do_read(32'h40, rd, nc);
    chk("rst_mid_kept", rd, 32'h1);

    // LATENCY=0 instance: held read is acked every second cycle.
    @(posedge clk); #2 sel_dut = 0;
    do_write(32'h8, 32'h77, 4'hF, nc);
    chk("wr_lat0_cycles", nc, 32'd2);
    @(posedge clk); #2;
    s_dr_re = 1; s_dr_addr = 32'h8; s_dr_sel = 4'h1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("b2b_ack", {31'b0, m_dr_ack}, {31'b0, (k % 2) == 0});
      chk("b2b_busy", {31'b0, m_busy}, {31'b0, (k % 2) == 0});
      if ((k % 2) == 0) chk("b2b_data", m_dr_data, 32'h77);
    end
    @(posedge clk); #2 s_dr_re = 0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
